// File: rtl/alu_seq16_pkg.sv
// Shared ALU op codes and op classification for the 16-bit ALU sequencer.
package alu_seq16_pkg;

    localparam int AC_W = 3;

    localparam logic [AC_W-1:0] AC_AD = 3'd0;
    localparam logic [AC_W-1:0] AC_SB = 3'd1;
    localparam logic [AC_W-1:0] AC_AN = 3'd2;
    localparam logic [AC_W-1:0] AC_OR = 3'd3;
    localparam logic [AC_W-1:0] AC_LS = 3'd4;
    localparam logic [AC_W-1:0] AC_MU = 3'd5;

    // Ops that run as a plain low-slice / high-slice pair
    function automatic logic is_slice_op(input logic [AC_W-1:0] op);
        return (op == AC_AD) || (op == AC_SB) || (op == AC_AN) || (op == AC_OR);
    endfunction

    function automatic logic op_known(input logic [AC_W-1:0] op);
        return is_slice_op(op) || (op == AC_LS) || (op == AC_MU);
    endfunction

endpackage

// File: rtl/alu_seq16_mul_step.sv
// Shift-add multiply state: bit index, shifting multiplicand and 16-bit accumulator.
module alu_seq16_mul_step (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        init,
    input  logic        adv,
    input  logic [15:0] mcand_in,
    input  logic [7:0]  hi_s,
    input  logic [7:0]  lo_s,
    output logic [3:0]  bit_idx,
    output logic [15:0] mcand,
    output logic [15:0] acc,
    output logic        last
);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            bit_idx <= 4'd0;
            mcand   <= 16'd0;
            acc     <= 16'd0;
        end else if (init) begin
            bit_idx <= 4'd0;
            mcand   <= mcand_in;
            acc     <= 16'd0;
        end else if (adv) begin
            // Bits shifted out of the multiplicand are product overflow and are dropped
            acc     <= {hi_s, lo_s};
            mcand   <= mcand << 1;
            bit_idx <= bit_idx + 4'd1;
        end
    end

    assign last = (bit_idx == 4'd15);

endmodule

// File: rtl/alu_seq16.sv
// Runs 16-bit add/sub/and/or/signed-less/multiply on the shared 8-bit alu,
// one byte slice per cycle, behind a start/busy/done handshake.
module alu_seq16
    import alu_seq16_pkg::*;
#(
    parameter int AC_N = AC_W
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            start,
    input  logic [AC_N-1:0] op,
    input  logic [15:0]     a,
    input  logic [15:0]     b,
    output logic            busy,
    output logic            done,
    output logic [15:0]     result,
    output logic            zero,
    output logic            carry,
    output logic            less,
    output logic [AC_N-1:0] alu_cs,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic            alu_cin,
    input  logic [7:0]      alu_s,
    input  logic            alu_zero,
    input  logic            alu_cout
);

    typedef enum logic [3:0] {
        IDLE, LO, HI, LSH, LSW, LSL, MLO, MHI, FIN
    } state_t;

    state_t          state, nxt;
    logic [AC_N-1:0] op_r;
    logic [15:0]     a_r, b_r;
    logic [7:0]      lo_s;
    logic            lo_zero, lo_cout;

    logic            mul_init, mul_adv, mul_last, mul_bit;
    logic [3:0]      mul_idx;
    logic [15:0]     mcand, acc;

    alu_seq16_mul_step u_mul (
        .Clock    (Clock),
        .Reset    (Reset),
        .init     (mul_init),
        .adv      (mul_adv),
        .mcand_in (a),
        .hi_s     (alu_s),
        .lo_s     (lo_s),
        .bit_idx  (mul_idx),
        .mcand    (mcand),
        .acc      (acc),
        .last     (mul_last)
    );

    assign mul_bit = b_r[mul_idx];
    assign busy    = (state != IDLE) && (state != FIN);
    assign done    = (state == FIN);

    always_comb begin
        nxt      = state;
        alu_a    = 8'd0;
        alu_b    = 8'd0;
        alu_cin  = 1'b0;
        mul_init = 1'b0;
        mul_adv  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_slice_op(op)) begin
                        nxt = LO;
                    end else if (op == AC_LS) begin
                        nxt = LSH;
                    end else if (op == AC_MU) begin
                        nxt      = MLO;
                        mul_init = 1'b1;
                    end else begin
                        nxt = FIN;
                    end
                end
            end
            LO: begin
                alu_a = a_r[7:0];
                alu_b = b_r[7:0];
                nxt   = HI;
            end
            HI: begin
                alu_a   = a_r[15:8];
                alu_b   = b_r[15:8];
                alu_cin = lo_cout;
                nxt     = FIN;
            end
            LSH: begin
                alu_a = a_r[15:8];
                alu_b = b_r[15:8];
                nxt   = ((a_r[15] != b_r[15]) || alu_s[0]) ? FIN : LSW;
            end
            // Swapped operands: the alu only answers unsigned "a < b"
            LSW: begin
                alu_a = b_r[15:8];
                alu_b = a_r[15:8];
                nxt   = alu_s[0] ? FIN : LSL;
            end
            LSL: begin
                alu_a = a_r[7:0];
                alu_b = b_r[7:0];
                nxt   = FIN;
            end
            MLO: begin
                alu_a = acc[7:0];
                alu_b = mul_bit ? mcand[7:0] : 8'd0;
                nxt   = MHI;
            end
            MHI: begin
                alu_a   = acc[15:8];
                alu_b   = mul_bit ? mcand[15:8] : 8'd0;
                alu_cin = lo_cout;
                mul_adv = 1'b1;
                nxt     = mul_last ? FIN : MLO;
            end
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            op_r    <= '0;
            a_r     <= 16'd0;
            b_r     <= 16'd0;
            lo_s    <= 8'd0;
            lo_zero <= 1'b0;
            lo_cout <= 1'b0;
            alu_cs  <= '0;
            result  <= 16'd0;
            zero    <= 1'b0;
            carry   <= 1'b0;
            less    <= 1'b0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        a_r   <= a;
                        b_r   <= b;
                        zero  <= 1'b0;
                        carry <= 1'b0;
                        less  <= 1'b0;
                        if (!op_known(op))
                            result <= 16'd0;
                        else
                            alu_cs <= (op == AC_MU) ? AC_AD : op;
                    end
                end
                LO, MLO: begin
                    lo_s    <= alu_s;
                    lo_zero <= alu_zero;
                    lo_cout <= alu_cout;
                end
                HI: begin
                    result <= {alu_s, lo_s};
                    zero   <= lo_zero & alu_zero;
                    carry  <= ((op_r == AC_AD) || (op_r == AC_SB)) & alu_cout;
                end
                LSH: begin
                    if (a_r[15] != b_r[15]) begin
                        less   <= a_r[15];
                        result <= {15'd0, a_r[15]};
                    end else if (alu_s[0]) begin
                        less   <= 1'b1;
                        result <= 16'd1;
                    end
                end
                LSW: begin
                    if (alu_s[0]) begin
                        less   <= 1'b0;
                        result <= 16'd0;
                    end
                end
                LSL: begin
                    less   <= alu_s[0];
                    result <= {15'd0, alu_s[0]};
                end
                MHI: begin
                    if (mul_last) begin
                        result <= {alu_s, lo_s};
                        zero   <= ({alu_s, lo_s} == 16'd0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq16.sv
// Directed bench for alu_seq16 with a behavioural 8-bit alu and a cycle-level result model.
module tb_alu_seq16;
    import alu_seq16_pkg::*;

    logic        Clock, Reset, start;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        busy, done, zero, carry, less;
    logic [15:0] result;
    logic [2:0]  alu_cs;
    logic [7:0]  alu_a, alu_b, alu_s;
    logic        alu_cin, alu_zero, alu_cout;

    int checks = 0;
    int failures = 0;

    alu_seq16 dut (
        .Clock(Clock), .Reset(Reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero), .carry(carry), .less(less),
        .alu_cs(alu_cs), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_s(alu_s), .alu_zero(alu_zero), .alu_cout(alu_cout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural 8-bit alu: SB is a - b - cin with cout as borrow; LS is unsigned a < b
    logic [8:0] t;
    always_comb begin
        t        = 9'd0;
        alu_s    = 8'd0;
        alu_cout = 1'b0;
        case (alu_cs)
            AC_AD: begin
                t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
                alu_s = t[7:0]; alu_cout = t[8];
            end
            AC_SB: begin
                t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
                alu_s = t[7:0]; alu_cout = t[8];
            end
            AC_AN:   alu_s = alu_a & alu_b;
            AC_OR:   alu_s = alu_a | alu_b;
            AC_LS:   alu_s = {7'd0, (alu_a < alu_b)};
            default: ;
        endcase
        alu_zero = (alu_s == 8'd0);
    end

    typedef struct packed {
        logic [7:0]  lat;
        logic [15:0] res;
        logic        z, c, l;
    } exp_t;

    function automatic exp_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        logic [16:0] s;
        e = '0;
        s = 17'd0;
        case (o)
            AC_AD: begin s = {1'b0, x} + {1'b0, y}; e.res = s[15:0]; e.c = s[16]; e.lat = 8'd3; end
            AC_SB: begin e.res = x - y; e.c = (x < y); e.lat = 8'd3; end
            AC_AN: begin e.res = x & y; e.lat = 8'd3; end
            AC_OR: begin e.res = x | y; e.lat = 8'd3; end
            AC_LS: begin
                e.l   = ($signed(x) < $signed(y));
                e.res = {15'd0, e.l};
                if (x[15] != y[15] || x[15:8] < y[15:8]) e.lat = 8'd2;
                else if (x[15:8] > y[15:8])             e.lat = 8'd3;
                else                                     e.lat = 8'd4;
            end
            AC_MU:   begin e.res = x * y; e.lat = 8'd33; end
            default: begin e.res = 16'd0; e.lat = 8'd1; end
        endcase
        if (o inside {AC_AD, AC_SB, AC_AN, AC_OR, AC_MU}) e.z = (e.res == 16'd0);
        return e;
    endfunction

    // pos: cycles since acceptance (0 = idle); outputs of the finished op become visible in FIN
    logic [7:0]  pos;
    exp_t        pend;
    logic [15:0] v_res;
    logic        v_z, v_c, v_l;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pos <= 8'd0; pend <= '0;
            v_res <= 16'd0; v_z <= 1'b0; v_c <= 1'b0; v_l <= 1'b0;
        end else if (pos == 8'd0) begin
            if (start) begin
                pend <= model(op, a, b);
                pos  <= 8'd1;
                v_z <= 1'b0; v_c <= 1'b0; v_l <= 1'b0;
            end
        end else if (pos == pend.lat) begin
            pos   <= 8'd0;
            v_res <= pend.res; v_z <= pend.z; v_c <= pend.c; v_l <= pend.l;
        end else begin
            pos <= pos + 8'd1;
        end
    end

    logic        m_done, m_busy, m_z, m_c, m_l;
    logic [15:0] m_res;
    assign m_done = (pos != 8'd0) && (pos == pend.lat);
    assign m_busy = (pos != 8'd0) && (pos < pend.lat);
    assign m_res  = m_done ? pend.res : v_res;
    assign m_z    = m_done ? pend.z : v_z;
    assign m_c    = m_done ? pend.c : v_c;
    assign m_l    = m_done ? pend.l : v_l;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
        chk("cyc_done", {31'd0, done}, {31'd0, m_done});
        chk("cyc_result", {16'd0, result}, {16'd0, m_res});
        chk("cyc_zero", {31'd0, zero}, {31'd0, m_z});
        chk("cyc_carry", {31'd0, carry}, {31'd0, m_c});
        chk("cyc_less", {31'd0, less}, {31'd0, m_l});
    end

    // Called at posedge+2 with the sequencer idle; returns at posedge+2 of the cycle after FIN
    task automatic run_op(input string nm, input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] er, input logic ez, input logic ec, input logic el, input int elat);
        int n, nb;
        bit got;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge Clock); #2 start = 1'b0;
        n = 1; nb = 0; got = 1'b0;
        while (!got && n < 80) begin
            @(negedge Clock);
            if (done) got = 1'b1;
            else begin
                if (busy) nb++;
                @(posedge Clock); #2;
                n++;
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s_timeout: no done within %0d cycles, expected at %0d", nm, n, elat);
        end else begin
            chk({nm, "_result"}, {16'd0, result}, {16'd0, er});
            chk({nm, "_zero"}, {31'd0, zero}, {31'd0, ez});
            chk({nm, "_carry"}, {31'd0, carry}, {31'd0, ec});
            chk({nm, "_less"}, {31'd0, less}, {31'd0, el});
            chk({nm, "_latency"}, n, elat);
            chk({nm, "_busy_cycles"}, nb, elat - 1);
        end
        @(posedge Clock); #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, d2;
        logic [15:0] r1, r2;
        Reset = 1'b0; start = 1'b0; op = 3'd0; a = 16'd0; b = 16'd0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_flags", {29'd0, zero, carry, less}, 32'd0);
        repeat (2) @(posedge Clock);
        #2 Reset = 1'b1;
        @(posedge Clock); #2;

        run_op("ad1",  AC_AD, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 1'b0, 1'b0, 3);
        run_op("ad2",  AC_AD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 3);
        run_op("sb1",  AC_SB, 16'h5A5A, 16'h0F0F, 16'h4B4B, 1'b0, 1'b0, 1'b0, 3);
        run_op("sb2",  AC_SB, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b1, 1'b0, 3);
        run_op("an1",  AC_AN, 16'h5A5A, 16'h0F0F, 16'h0A0A, 1'b0, 1'b0, 1'b0, 3);
        run_op("or1",  AC_OR, 16'h5A5A, 16'h0F0F, 16'h5F5F, 1'b0, 1'b0, 1'b0, 3);
        run_op("ls1",  AC_LS, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 2);
        run_op("ls2",  AC_LS, 16'h0105, 16'h0107, 16'h0001, 1'b0, 1'b0, 1'b1, 4);
        run_op("ls3",  AC_LS, 16'h0107, 16'h0105, 16'h0000, 1'b0, 1'b0, 1'b0, 4);
        run_op("ls4",  AC_LS, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 4);
        run_op("ls5",  AC_LS, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 2);
        run_op("ls6",  AC_LS, 16'h0200, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0, 3);
        run_op("mu1",  AC_MU, 16'd300,  16'd200,  16'hEA60, 1'b0, 1'b0, 1'b0, 33);
        run_op("mu2",  AC_MU, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, 33);
        run_op("mu3",  AC_MU, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 33);
        run_op("undf", 3'd6,  16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b0, 1);

        // start held high across an AD; operand change while busy must not be latched
        op = AC_AD; a = 16'h0001; b = 16'h0002; start = 1'b1;
        nd = 0; d2 = -1; r1 = 16'd0; r2 = 16'd0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) a = 16'h0100;
            if (i == 5) start = 1'b0;
            @(negedge Clock);
            if (done) begin
                nd++;
                if (nd == 1) r1 = result;
                else begin r2 = result; d2 = i; end
            end
            @(posedge Clock); #2;
        end
        chk("b2b_done_count", nd, 2);
        chk("b2b_first_result", {16'd0, r1}, 32'h0003);
        chk("b2b_second_result", {16'd0, r2}, 32'h0102);
        chk("b2b_second_done_cycle", d2, 7);

        // reset in the middle of a multiply
        op = AC_MU; a = 16'd300; b = 16'd200; start = 1'b1;
        @(posedge Clock); #2 start = 1'b0;
        repeat (9) @(posedge Clock);
        #2 Reset = 1'b0;
        #1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_result", {16'd0, result}, 32'd0);
        chk("mrst_flags", {29'd0, zero, carry, less}, 32'd0);
        repeat (2) @(posedge Clock);
        #2 Reset = 1'b1;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (done) nd++;
        end
        chk("mrst_no_done", nd, 0);
        @(posedge Clock); #2;
        run_op("ad3", AC_AD, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 1'b0, 1'b0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
